// File: rtl/fb_filter_pkg.sv
// Shared configuration-stage package: feedback filter defaults, the CONF_BITS
// width used by the configuration stage, and the hysteresis decision helper.
package fb_filter_pkg;

  localparam int WIN_LOG2_DEF = 4;
  localparam int THR_HI_DEF   = 12;
  localparam int THR_LO_DEF   = 4;
  localparam int CONF_BITS    = 8;

  typedef struct packed {
    logic invu;
    logic invd;
  } fb_pair_t;

  // High-sample count at or above hi decides 1, at or below lo decides 0,
  // anything in between keeps the previous level.
  function automatic logic hyst_level(input int tot, input int thr_hi,
                                      input int thr_lo, input logic prev);
    if (tot >= thr_hi) return 1'b1;
    if (tot <= thr_lo) return 1'b0;
    return prev;
  endfunction

endpackage

// File: rtl/fb_filter_if.sv
// Inverter-chain feedback bundle between the comparator side and the
// configuration stage: enable, raw comparator levels, filtered results.
interface fb_filter_if;
  logic EN;
  logic INVU_RAW;
  logic INVD_RAW;
  logic O_INVU;
  logic O_INVD;
  logic FB_VALID;
  logic CONFLICT;

  modport master (
    output EN, INVU_RAW, INVD_RAW,
    input  O_INVU, O_INVD, FB_VALID, CONFLICT
  );

  modport slave (
    input  EN, INVU_RAW, INVD_RAW,
    output O_INVU, O_INVD, FB_VALID, CONFLICT
  );
endinterface

// File: rtl/fb_filter_sync.sv
// Two-flop synchronizer for one asynchronous comparator level, cleared by
// the synchronous reset.
module fb_sync (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/fb_filter.sv
// Windowed majority filter with hysteresis for the up/down inverter-chain
// comparators; emits one registered decision per 2^WIN_LOG2 enabled cycles.
module fb_filter
  import fb_filter_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int THR_HI   = THR_HI_DEF,
  parameter int THR_LO   = THR_LO_DEF
) (
  input logic        CLK,
  input logic        RST,
  fb_filter_if.slave fb
);

  if (WIN_LOG2 < 1 || !(THR_LO < THR_HI) || THR_HI > (1 << WIN_LOG2)) begin : g_param_check
    $error("fb_filter: parameters must satisfy THR_LO < THR_HI <= 2**WIN_LOG2");
  end

  logic invu_s, invd_s;

  fb_sync u_sync_u (.CLK(CLK), .RST(RST), .d(fb.INVU_RAW), .q(invu_s));
  fb_sync u_sync_d (.CLK(CLK), .RST(RST), .d(fb.INVD_RAW), .q(invd_s));

  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2:0]   acc_u, acc_d;
  logic [WIN_LOG2:0]   tot_u, tot_d;
  logic                win_end;
  fb_pair_t            dec;
  fb_pair_t            out_q;
  logic                valid_q, conflict_q;

  // The window-end total includes the sample arriving in that same cycle.
  always_comb begin
    tot_u    = acc_u + {{WIN_LOG2{1'b0}}, invu_s};
    tot_d    = acc_d + {{WIN_LOG2{1'b0}}, invd_s};
    win_end  = (win_cnt == '1);
    dec.invu = hyst_level(int'(tot_u), THR_HI, THR_LO, out_q.invu);
    dec.invd = hyst_level(int'(tot_d), THR_HI, THR_LO, out_q.invd);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      win_cnt    <= '0;
      acc_u      <= '0;
      acc_d      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      if (!fb.EN) begin
        win_cnt <= '0;
        acc_u   <= '0;
        acc_d   <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        if (win_end) begin
          acc_u   <= '0;
          acc_d   <= '0;
          valid_q <= 1'b1;
          // Both chains claiming 1 is contradictory: report it and drive neither.
          if (dec.invu && dec.invd) begin
            out_q      <= '0;
            conflict_q <= 1'b1;
          end else begin
            out_q <= dec;
          end
        end else begin
          acc_u <= tot_u;
          acc_d <= tot_d;
        end
      end
    end
  end

  assign fb.O_INVU   = out_q.invu;
  assign fb.O_INVD   = out_q.invd;
  assign fb.FB_VALID = valid_q;
  assign fb.CONFLICT = conflict_q;

endmodule

// File: tb/tb_fb_filter.sv
// Self-checking bench for fb_filter: directed scenarios plus randomized
// windows, compared each cycle against a window-level reference model.
module tb_fb_filter;
  localparam int WL  = 4;
  localparam int HI  = 12;
  localparam int LO  = 4;
  localparam int WIN = 1 << WL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_filter_if fb();

  fb_filter #(.WIN_LOG2(WL), .THR_HI(HI), .THR_LO(LO)) dut (
    .CLK(clk),
    .RST(rst),
    .fb (fb)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: raw values reach the filter two edges late; a window is
  // simply the list of the last WIN enabled samples, counted when full.
  logic hist_u[$];
  logic hist_d[$];
  logic win_u[$];
  logic win_d[$];
  logic m_invu, m_invd, m_valid, m_conflict;

  function automatic logic level(input int n, input logic prev);
    if (n >= HI) return 1'b1;
    if (n <= LO) return 1'b0;
    return prev;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic u, input logic d);
    logic su, sd, du, dd;
    int nu, nd;
    su = hist_u.pop_front();
    sd = hist_d.pop_front();
    hist_u.push_back(u);
    hist_d.push_back(d);
    m_valid    = 1'b0;
    m_conflict = 1'b0;
    if (r) begin
      hist_u = '{1'b0, 1'b0};
      hist_d = '{1'b0, 1'b0};
      win_u.delete();
      win_d.delete();
      m_invu = 1'b0;
      m_invd = 1'b0;
    end else if (!e) begin
      win_u.delete();
      win_d.delete();
    end else begin
      win_u.push_back(su);
      win_d.push_back(sd);
      if (win_u.size() == WIN) begin
        nu = 0;
        nd = 0;
        foreach (win_u[i]) if (win_u[i]) nu++;
        foreach (win_d[i]) if (win_d[i]) nd++;
        du = level(nu, m_invu);
        dd = level(nd, m_invd);
        m_valid = 1'b1;
        if (du && dd) begin
          m_invu     = 1'b0;
          m_invd     = 1'b0;
          m_conflict = 1'b1;
        end else begin
          m_invu = du;
          m_invd = dd;
        end
        win_u.delete();
        win_d.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic u, input logic d);
    @(negedge clk);
    rst         = r;
    fb.EN       = e;
    fb.INVU_RAW = u;
    fb.INVD_RAW = d;
    @(posedge clk);
    model_edge(r, e, u, d);
    #1;
    chk("o_invu",   fb.O_INVU,   m_invu);
    chk("o_invd",   fb.O_INVD,   m_invd);
    chk("fb_valid", fb.FB_VALID, m_valid);
    chk("conflict", fb.CONFLICT, m_conflict);
  endtask

  // Steps with fixed inputs until FB_VALID; returns the edge index or -1.
  task automatic until_valid(input logic u, input logic d, output int n);
    n = -1;
    for (int i = 1; i <= 3 * WIN; i++) begin
      step(1'b0, 1'b1, u, d);
      if (fb.FB_VALID === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int pu, pd;
    logic saw_both;
    logic e, r;

    rst         = 1'b1;
    fb.EN       = 1'b0;
    fb.INVU_RAW = 1'b0;
    fb.INVD_RAW = 1'b0;
    hist_u = '{1'b0, 1'b0};
    hist_d = '{1'b0, 1'b0};
    m_invu = 1'b0; m_invd = 1'b0; m_valid = 1'b0; m_conflict = 1'b0;

    // Quiet inputs: first FB_VALID after the 16th post-release edge (17th cycle).
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    until_valid(1'b0, 1'b0, n);
    chk_int("idle_first_valid_edge", n, WIN);
    chk("idle_o_invu", fb.O_INVU, 1'b0);
    chk("idle_o_invd", fb.O_INVD, 1'b0);

    // Up chain high from release: 14/16 then 16/16, O_INVU set and held.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    until_valid(1'b1, 1'b0, n);
    chk_int("up_first_valid_edge", n, WIN);
    chk("up_first_o_invu", fb.O_INVU, 1'b1);
    until_valid(1'b1, 1'b0, n);
    chk_int("up_second_valid_edge", n, WIN);
    chk("up_second_o_invu", fb.O_INVU, 1'b1);

    // Hysteresis: 8/16 holds 1, 3/16 drops to 0.
    for (int i = 0; i < 2 * WIN; i++) step(1'b0, 1'b1, (i % WIN) < 8, 1'b0);
    chk("hyst_hold_o_invu", fb.O_INVU, 1'b1);
    for (int i = 0; i < 2 * WIN; i++) step(1'b0, 1'b1, (i % WIN) < 3, 1'b0);
    chk("hyst_drop_o_invu", fb.O_INVU, 1'b0);

    // Both chains high: CONFLICT with FB_VALID, outputs forced low.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    saw_both = 1'b0;
    for (int i = 0; i < 2 * WIN + 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      if (fb.FB_VALID === 1'b1 && fb.CONFLICT === 1'b1) saw_both = 1'b1;
    end
    chk("conflict_with_valid", saw_both, 1'b1);

    // Reset at WIN_CNT=9 after O_INVD=1: partial window discarded.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    until_valid(1'b0, 1'b1, n);
    chk("down_o_invd", fb.O_INVD, 1'b1);
    repeat (9) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("abort_o_invd", fb.O_INVD, 1'b0);
    chk("abort_no_valid", fb.FB_VALID, 1'b0);
    until_valid(1'b0, 1'b1, n);
    chk_int("abort_next_valid_edge", n, WIN);

    // EN low for 5 cycles mid-window: hold, no pulses, full window restarts.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    until_valid(1'b1, 1'b0, n);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("en_low_o_invu_held", fb.O_INVU, 1'b1);
    until_valid(1'b1, 1'b0, n);
    chk_int("en_restart_valid_edge", n, WIN);

    // Randomized windows with occasional EN drops and resets.
    for (int w = 0; w < 30; w++) begin
      pu = 25 * $urandom_range(4);
      pd = 25 * $urandom_range(4);
      for (int i = 0; i < WIN; i++) begin
        e = ($urandom_range(99) >= 3);
        r = ($urandom_range(199) == 0);
        step(r, e, $urandom_range(99) < pu, $urandom_range(99) < pd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fb_filter.md
FB_FILTER -- requirements
Module: fb_filter

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 4, log2 of decision window length in CLK cycles.
REQ-002 SHALL have parameter THR_HI, default 12, high-sample count at or above which a channel decides 1.
REQ-003 SHALL have parameter THR_LO, default 4, high-sample count at or below which a channel decides 0.
REQ-004 SHALL have port CLK  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port EN  input  1  filter enable.
REQ-007 SHALL have port INVU_RAW  input  1  asynchronous raw comparator output, pull-up inverter chain.
REQ-008 SHALL have port INVD_RAW  input  1  asynchronous raw comparator output, pull-down inverter chain.
REQ-009 SHALL have port O_INVU  output  1  filtered up feedback to the configuration stage.
REQ-010 SHALL have port O_INVD  output  1  filtered down feedback to the configuration stage.
REQ-011 SHALL have port FB_VALID  output  1  one-cycle pulse marking an O_INVU/O_INVD update.
REQ-012 SHALL have port CONFLICT  output  1  one-cycle pulse when both channels decided 1 in the same window.

Function
REQ-013 SHALL pass each RAW input through a two-flop synchronizer before any other use.
REQ-014 SHALL keep window counter WIN_CNT, width WIN_LOG2, incrementing each EN cycle and wrapping from 2^WIN_LOG2-1 to 0.
REQ-015 SHALL keep accumulators ACC_U and ACC_D, width WIN_LOG2+1, each adding its synchronized sample every EN cycle; no saturation is needed.
REQ-016 SHALL, in the cycle WIN_CNT equals 2^WIN_LOG2-1, form TOT = ACC + current sample per channel, then clear both accumulators for the next window.
REQ-017 SHALL decide per channel: TOT >= THR_HI gives 1; TOT <= THR_LO gives 0; otherwise the previous output level is held (hysteresis).
REQ-018 SHALL, if both decisions are 1, drive O_INVU=0 and O_INVD=0 and pulse CONFLICT.
REQ-019 SHALL register the decisions into O_INVU/O_INVD and pulse FB_VALID in the cycle after the window-end cycle; outputs SHALL be otherwise stable.
REQ-020 SHALL, while EN=0, hold WIN_CNT and both accumulators at 0, hold O_INVU/O_INVD, and drive FB_VALID=0 and CONFLICT=0; synchronizers keep running.
REQ-021 SHALL restart a full window from WIN_CNT=0 on the first cycle after EN rises.
REQ-022 SHALL have latency from a RAW change to a possible output change of 2 sync cycles plus at most 2^WIN_LOG2+1 cycles.
REQ-023 SHALL require THR_LO < THR_HI <= 2^WIN_LOG2; violating parameters SHALL be rejected at elaboration.

Reset
REQ-024 SHALL, on RST=1 at a CLK edge, clear synchronizer flops, WIN_CNT, ACC_U, ACC_D, O_INVU, O_INVD, FB_VALID and CONFLICT to 0.
REQ-025 SHALL give RST priority over EN; RST mid-window discards the partial window, with no FB_VALID for it.
REQ-026 SHALL, when RST falls with EN=1, produce the first FB_VALID exactly 2^WIN_LOG2+1 cycles after the first non-reset edge.

Structure
REQ-027 SHALL take WIN_LOG2/THR_HI/THR_LO defaults from the shared conf package, alongside the CONF_BITS width used by the configuration stage.
REQ-028 SHALL instantiate sub-module fb_sync (two-flop synchronizer, synchronous reset) once per RAW input.
REQ-029 SHALL connect O_INVU/O_INVD directly to the configuration stage's O_INVU/O_INVD inputs on the same CLK.

Verification (WIN_LOG2=4, THR_HI=12, THR_LO=4)
REQ-030 SHALL cover: RST high 3 cycles, then EN=1, RAW=0 -> all outputs 0; FB_VALID first pulses 17 cycles after release with O_INVU=O_INVD=0.
REQ-031 SHALL cover: INVU_RAW=1, INVD_RAW=0 from reset release -> first window TOT_U=14 so O_INVU=1, O_INVD=0 with FB_VALID; second window TOT_U=16, O_INVU stays 1.
REQ-032 SHALL cover: O_INVU=1, then INVU high 8/16 samples -> O_INVU holds 1; next window 3/16 -> O_INVU=0.
REQ-033 SHALL cover: both RAW=1 steady -> TOT 16/16, O_INVU=O_INVD=0, CONFLICT and FB_VALID pulse together.
REQ-034 SHALL cover: RST pulsed at WIN_CNT=9 after O_INVD=1 -> O_INVD=0 next cycle, no FB_VALID for the aborted window, next FB_VALID 17 cycles after release.
REQ-035 SHALL cover: EN low for 5 cycles mid-window with RAW=1 -> outputs hold, no pulses; after EN rises, FB_VALID arrives 17 cycles later.
